seg_frame_serializer: RTL and testbench
=======================================

# seg_frame_serializer

Upstream stage of the seven-segment display driver: converts a parallel 96-bit display frame or a 12-bit brightness word into the four-wire serial protocol (serial clock, data, latch strobe, pwm strobe) that the display driver's shift register consumes. It replaces bit-banging by the microcontroller, so any FPGA-side logic can push a frame with a single-cycle request. It sits between frame-generation logic (timekeeping/alarm) and the display driver's `clk`/`data`/`latch`/`pwm` inputs.

## Interface
Parameters:
- `CLK_DIV`, 4: system clocks per serial half-phase, ≥1.
- `FRAME_BITS`, 96: frame width. Per digit: red[6:0], pad, green[6:0], pad, anode[6:0], pad, digit 4 in the top byte group.
- `BRIGHT_BITS`, 12: brightness word width.

Ports:
- `clk` in 1: system clock. This block has one clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `frame_in` in FRAME_BITS: frame, sampled on an accepted `start_frame`.
- `start_frame` in 1: single-cycle frame request.
- `bright_in` in BRIGHT_BITS: brightness, sampled on every `start_bright`.
- `start_bright` in 1: single-cycle brightness request.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse at the end of each transfer.
- `frame_ovf` out 1: one-cycle pulse when a `start_frame` is dropped.
- `sclk` out 1: serial clock to the display `clk`.
- `sdata` out 1: serial data to the display `data`.
- `slatch` out 1: latch strobe to the display `latch`.
- `spwm` out 1: brightness strobe to the display `pwm`.

## Operation
- States: IDLE, BIT_LO, BIT_HI, STB_SETUP, STB_HI. Each state holds for CLK_DIV cycles, counted by a phase counter. The counter reloads on every state entry.
- IDLE:
  - `start_frame` loads the shift register with `frame_in`, sets kind=FRAME, sets N=FRAME_BITS, and moves to BIT_LO.
  - Otherwise, `start_bright` or a set pending flag loads `bright_in` (or the pending word), sets kind=BRIGHT, sets N=BRIGHT_BITS, and moves to BIT_LO.
- BIT_LO: `sclk`=0 and `sdata` drives the current MSB. Moves to BIT_HI.
- BIT_HI: `sclk`=1 and `sdata` is held. On exit the register shifts left one place and the bit counter decrements.
  - If bits remain, the next state is BIT_LO.
  - Otherwise the next state is STB_SETUP.
- Bit order is MSB first: `frame_in[FRAME_BITS-1]` is sent first and `frame_in[0]` last. This places the frame in the receiver's shift register unchanged.
- STB_SETUP: `sclk`=0 and `sdata`=0. Moves to STB_HI.
- STB_HI: `slatch`=1 if kind=FRAME, or `spwm`=1 if kind=BRIGHT.
  - On exit, `done` pulses.
  - If a brightness word is pending, it is loaded and the next state is BIT_LO with `busy` held at 1.
  - Otherwise the next state is IDLE.
- Pending brightness:
  - `start_bright` while busy stores `bright_in` in a pending register and sets the pending flag. The last request wins.
  - The flag clears when the pending word is loaded.
- `start_frame` while busy is ignored and `frame_ovf`=1 in the following cycle. `frame_in` is not sampled.
- Simultaneous `start_frame` and `start_bright` in IDLE: the frame is sent first and the brightness word becomes pending.
- `busy`=1 from the cycle after acceptance until the cycle `done` pulses. `busy`=0 in the cycle in which `done`=1, unless a pending transfer chains.

## Timing
- Reset values: every output is 0 (`busy`, `done`, `frame_ovf`, `sclk`, `sdata`, `slatch`, `spwm`). The state is IDLE and the pending flag is cleared.
- Asserting `rst_n` low mid-transfer forces all outputs to 0 immediately (asynchronous) and aborts the transfer. No strobe is issued.
- All outputs are registered and glitch-free. `sdata` is stable at least CLK_DIV cycles before and after each `sclk` rising edge.
- Latency is counted from the acceptance edge to the `done` cycle:
  - One transfer takes 2·CLK_DIV·N + 2·CLK_DIV cycles.
  - Frame at CLK_DIV=4: 776 cycles.
  - Brightness at CLK_DIV=4: 104 cycles.
- Strobe width is CLK_DIV cycles. The first `sclk` rise of a chained transfer occurs CLK_DIV cycles after the strobe falls.
- A new `start_*` is accepted in IDLE only, including the cycle in which `done`=1 and `busy`=0.

## Test plan
- Reset → all outputs 0. Then `rst_n` high with no start → outputs stay 0 for 100 cycles.
- `start_frame`, frame=96'h7F_7F_7F_00_…_55 (any known pattern), CLK_DIV=4:
  - A bench model of the display receiver (shift on `sclk` rise, capture on `slatch` rise) holds exactly that value.
  - `done` arrives at cycle 776.
  - 96 `sclk` rises and one `slatch` pulse 4 cycles wide.
- `start_bright`, bright=12'hA5C → the receiver model's low 12 bits equal 12'hA5C at the `spwm` rise, `done` arrives at cycle 104, and `slatch` never asserts.
- `start_bright` (12'h123) at cycle 200 of a frame, then `start_bright` (12'h456) at cycle 300:
  - The frame completes and `done` pulses.
  - The 12'h456 transfer follows with no IDLE gap and `busy` continuously 1.
  - `spwm` captures 12'h456.
- `start_frame` at cycle 50 of a frame → `frame_ovf`=1 for exactly one cycle and the first frame is delivered intact. Simultaneous `start_frame` + `start_bright` in IDLE → frame first, then brightness.
- `rst_n` low at cycle 400 of a frame → outputs 0 within the same cycle, no `slatch` pulse. A later transfer after reset is correct.

Source files
------------

// File: rtl/seg_frame_serializer.sv
// Serializes a 96-bit display frame or a 12-bit brightness word onto the
// display driver's clk/data/latch/pwm wires, MSB first, with a chained pending brightness slot.
module seg_frame_serializer #(
    parameter int CLK_DIV     = 4,
    parameter int FRAME_BITS  = 96,
    parameter int BRIGHT_BITS = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FRAME_BITS-1:0]  frame_in,
    input  logic                   start_frame,
    input  logic [BRIGHT_BITS-1:0] bright_in,
    input  logic                   start_bright,
    output logic                   busy,
    output logic                   done,
    output logic                   frame_ovf,
    output logic                   sclk,
    output logic                   sdata,
    output logic                   slatch,
    output logic                   spwm
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(FRAME_BITS + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        BIT_LO,
        BIT_HI,
        STB_SETUP,
        STB_HI
    } state_t;

    state_t                 state, state_nx;
    logic [PW-1:0]          phase, phase_nx;
    logic [CW-1:0]          bits_left, bits_left_nx;
    logic [FRAME_BITS-1:0]  shreg, shreg_nx;
    logic                   kind_frame, kind_frame_nx;
    logic                   pend_flag, pend_flag_nx;
    logic [BRIGHT_BITS-1:0] pend_word, pend_word_nx;
    logic                   done_nx, ovf_nx;
    logic                   phase_end;

    // Brightness words ride in the top bits so the MSB-first shifter needs no second path
    function automatic logic [FRAME_BITS-1:0] align_bright(input logic [BRIGHT_BITS-1:0] w);
        logic [FRAME_BITS-1:0] r;
        r = '0;
        r[FRAME_BITS-1 -: BRIGHT_BITS] = w;
        return r;
    endfunction

    assign phase_end = (phase == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            phase      <= '0;
            bits_left  <= '0;
            shreg      <= '0;
            kind_frame <= 1'b0;
            pend_flag  <= 1'b0;
            pend_word  <= '0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            bits_left  <= bits_left_nx;
            shreg      <= shreg_nx;
            kind_frame <= kind_frame_nx;
            pend_flag  <= pend_flag_nx;
            pend_word  <= pend_word_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        phase_nx      = phase;
        bits_left_nx  = bits_left;
        shreg_nx      = shreg;
        kind_frame_nx = kind_frame;
        pend_flag_nx  = pend_flag;
        pend_word_nx  = pend_word;
        done_nx       = 1'b0;
        ovf_nx        = 1'b0;

        if (!phase_end) begin
            phase_nx = phase - 1'b1;
        end

        case (state)
            IDLE: begin
                if (start_frame) begin
                    shreg_nx      = frame_in;
                    kind_frame_nx = 1'b1;
                    bits_left_nx  = CW'(FRAME_BITS);
                    phase_nx      = PHASE_LAST;
                    state_nx      = BIT_LO;
                end else if (start_bright || pend_flag) begin
                    shreg_nx      = align_bright(start_bright ? bright_in : pend_word);
                    kind_frame_nx = 1'b0;
                    bits_left_nx  = CW'(BRIGHT_BITS);
                    pend_flag_nx  = 1'b0;
                    phase_nx      = PHASE_LAST;
                    state_nx      = BIT_LO;
                end
            end
            BIT_LO: begin
                if (phase_end) begin
                    phase_nx = PHASE_LAST;
                    state_nx = BIT_HI;
                end
            end
            BIT_HI: begin
                if (phase_end) begin
                    shreg_nx     = shreg << 1;
                    bits_left_nx = bits_left - 1'b1;
                    phase_nx     = PHASE_LAST;
                    state_nx     = (bits_left == CW'(1)) ? STB_SETUP : BIT_LO;
                end
            end
            STB_SETUP: begin
                if (phase_end) begin
                    phase_nx = PHASE_LAST;
                    state_nx = STB_HI;
                end
            end
            STB_HI: begin
                if (phase_end) begin
                    done_nx  = 1'b1;
                    phase_nx = PHASE_LAST;
                    if (pend_flag) begin
                        shreg_nx      = align_bright(pend_word);
                        kind_frame_nx = 1'b0;
                        bits_left_nx  = CW'(BRIGHT_BITS);
                        pend_flag_nx  = 1'b0;
                        state_nx      = BIT_LO;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A new brightness request must win over a pending load happening in the same cycle
        if (start_bright && ((state != IDLE) || start_frame)) begin
            pend_word_nx = bright_in;
            pend_flag_nx = 1'b1;
        end
        if (start_frame && (state != IDLE)) begin
            ovf_nx = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_ovf <= 1'b0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            slatch    <= 1'b0;
            spwm      <= 1'b0;
        end else begin
            busy      <= (state_nx != IDLE);
            done      <= done_nx;
            frame_ovf <= ovf_nx;
            sclk      <= (state_nx == BIT_HI);
            sdata     <= ((state_nx == BIT_LO) || (state_nx == BIT_HI)) ? shreg_nx[FRAME_BITS-1] : 1'b0;
            slatch    <= (state_nx == STB_HI) && kind_frame_nx;
            spwm      <= (state_nx == STB_HI) && !kind_frame_nx;
        end
    end

endmodule

// File: tb/tb_seg_frame_serializer.sv
// Bench for seg_frame_serializer: a model of the display receiver plus a queue of
// expected strobes checks content, latency, busy continuity, overflow and reset abort.
module tb_seg_frame_serializer;

    localparam int D        = 4;
    localparam int FB       = 96;
    localparam int BB       = 12;
    localparam int LAT_FRM  = 2 * D * FB + 2 * D;
    localparam int LAT_BRT  = 2 * D * BB + 2 * D;

    typedef struct packed {
        logic          is_frame;
        logic [FB-1:0] val;
    } xfer_t;

    logic          clk;
    logic          rst_n;
    logic [FB-1:0] frame_in;
    logic          start_frame;
    logic [BB-1:0] bright_in;
    logic          start_bright;
    logic          busy, done, frame_ovf, sclk, sdata, slatch, spwm;

    int    tests_run;
    int    tests_failed;
    int    sclk_rises;
    int    latch_cnt;
    int    pwm_cnt;
    int    ovf_cnt;
    time   latch_rise_t;
    time   pwm_rise_t;
    logic [FB-1:0] rx;
    xfer_t exp_q[$];

    seg_frame_serializer #(
        .CLK_DIV     (D),
        .FRAME_BITS  (FB),
        .BRIGHT_BITS (BB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_in     (frame_in),
        .start_frame  (start_frame),
        .bright_in    (bright_in),
        .start_bright (start_bright),
        .busy         (busy),
        .done         (done),
        .frame_ovf    (frame_ovf),
        .sclk         (sclk),
        .sdata        (sdata),
        .slatch       (slatch),
        .spwm         (spwm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Display receiver model: shifts on sclk rise, strobes check against the expected queue
    always @(posedge sclk) begin
        rx = {rx[FB-2:0], sdata};
        sclk_rises++;
    end

    always @(posedge slatch) begin
        xfer_t x;
        latch_cnt++;
        latch_rise_t = $time;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_latch", 1, 0);
        end else begin
            x = exp_q.pop_front();
            checkOutput("latch_kind", x.is_frame, 1);
            checkOutput("latch_frame", rx, x.val);
        end
    end

    always @(posedge spwm) begin
        xfer_t x;
        pwm_cnt++;
        pwm_rise_t = $time;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_pwm", 1, 0);
        end else begin
            x = exp_q.pop_front();
            checkOutput("pwm_kind", x.is_frame, 0);
            checkOutput("pwm_bright", rx[BB-1:0], x.val[BB-1:0]);
        end
    end

    always @(negedge slatch) begin
        if (rst_n) checkOutput("latch_width", ($time - latch_rise_t) / 10, D);
    end

    always @(negedge spwm) begin
        if (rst_n) checkOutput("pwm_width", ($time - pwm_rise_t) / 10, D);
    end

    always @(negedge clk) begin
        if (frame_ovf) ovf_cnt++;
    end

    task automatic applyStimulus(input logic sf, input logic [FB-1:0] f, input logic sb, input logic [BB-1:0] b);
        @(negedge clk);
        start_frame  = sf;
        frame_in     = f;
        start_bright = sb;
        bright_in    = b;
        @(posedge clk);
        #1;
        start_frame  = 1'b0;
        start_bright = 1'b0;
    endtask

    task automatic waitDone(input int exp_lat, input logic exp_busy, input string tag);
        int   lat;
        logic gap;
        lat = 0;
        gap = 1'b0;
        while (lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (!busy) gap = 1'b1;
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy_gap"}, gap, 0);
        checkOutput({tag, "_busy_at_done"}, busy, exp_busy);
    endtask

    function automatic logic [FB-1:0] randFrame();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [6:0] outBits();
        return {busy, done, frame_ovf, sclk, sdata, slatch, spwm};
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [FB-1:0] f;
        logic [BB-1:0] b;
        logic [6:0]    seen;
        int            snap;

        tests_run    = 0;
        tests_failed = 0;
        sclk_rises   = 0;
        latch_cnt    = 0;
        pwm_cnt      = 0;
        ovf_cnt      = 0;
        rx           = '0;
        rst_n        = 1'b0;
        start_frame  = 1'b0;
        start_bright = 1'b0;
        frame_in     = '0;
        bright_in    = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", outBits(), 0);
        rst_n = 1'b1;
        seen  = '0;
        repeat (100) begin
            @(posedge clk);
            #1;
            seen |= outBits();
        end
        checkOutput("idle_quiet", seen, 0);

        f = 96'h7F7F7F00_AAAA5555_00000055;
        sclk_rises = 0;
        exp_q.push_back('{1'b1, f});
        applyStimulus(1'b1, f, 1'b0, '0);
        waitDone(LAT_FRM, 1'b0, "frame");
        checkOutput("frame_sclk_rises", sclk_rises, FB);
        checkOutput("frame_latch_count", latch_cnt, 1);

        sclk_rises = 0;
        snap = latch_cnt;
        exp_q.push_back('{1'b0, {84'd0, 12'hA5C}});
        applyStimulus(1'b0, '0, 1'b1, 12'hA5C);
        waitDone(LAT_BRT, 1'b0, "bright");
        checkOutput("bright_sclk_rises", sclk_rises, BB);
        checkOutput("bright_no_latch", latch_cnt, snap);

        // Two brightness requests during a frame: the later one chains with no idle gap
        f = randFrame();
        exp_q.push_back('{1'b1, f});
        exp_q.push_back('{1'b0, {84'd0, 12'h456}});
        applyStimulus(1'b1, f, 1'b0, '0);
        fork
            waitDone(LAT_FRM, 1'b1, "chain_frame");
            begin
                repeat (199) @(posedge clk);
                applyStimulus(1'b0, '0, 1'b1, 12'h123);
                repeat (99) @(posedge clk);
                applyStimulus(1'b0, '0, 1'b1, 12'h456);
            end
        join
        waitDone(LAT_BRT, 1'b0, "chain_bright");

        f = randFrame();
        ovf_cnt = 0;
        exp_q.push_back('{1'b1, f});
        applyStimulus(1'b1, f, 1'b0, '0);
        fork
            waitDone(LAT_FRM, 1'b0, "ovf_frame");
            begin
                repeat (49) @(posedge clk);
                applyStimulus(1'b1, ~f, 1'b0, '0);
            end
        join
        checkOutput("ovf_pulse_cycles", ovf_cnt, 1);

        f = randFrame();
        b = BB'($urandom);
        exp_q.push_back('{1'b1, f});
        exp_q.push_back('{1'b0, {84'd0, b}});
        applyStimulus(1'b1, f, 1'b1, b);
        waitDone(LAT_FRM, 1'b1, "simul_frame");
        waitDone(LAT_BRT, 1'b0, "simul_bright");

        // Abort a frame with reset: outputs clear at once and no strobe follows
        f = randFrame();
        snap = latch_cnt;
        applyStimulus(1'b1, f, 1'b0, '0);
        repeat (400) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_outputs", outBits(), 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = '0;
        repeat (900) begin
            @(posedge clk);
            #1;
            seen |= outBits();
        end
        checkOutput("abort_quiet", seen, 0);
        checkOutput("abort_no_latch", latch_cnt, snap);

        for (int i = 0; i < 6; i++) begin
            int kind;
            int when;
            kind = int'($urandom_range(0, 2));
            f = randFrame();
            b = BB'($urandom);
            if (kind == 0) begin
                exp_q.push_back('{1'b0, {84'd0, b}});
                applyStimulus(1'b0, '0, 1'b1, b);
                waitDone(LAT_BRT, 1'b0, "rand_bright");
            end else if (kind == 1) begin
                exp_q.push_back('{1'b1, f});
                applyStimulus(1'b1, f, 1'b0, '0);
                waitDone(LAT_FRM, 1'b0, "rand_frame");
            end else begin
                when = int'($urandom_range(10, 700));
                exp_q.push_back('{1'b1, f});
                exp_q.push_back('{1'b0, {84'd0, b}});
                applyStimulus(1'b1, f, 1'b0, '0);
                fork
                    waitDone(LAT_FRM, 1'b1, "rand_chain_frame");
                    begin
                        repeat (when - 1) @(posedge clk);
                        applyStimulus(1'b0, '0, 1'b1, b);
                    end
                join
                waitDone(LAT_BRT, 1'b0, "rand_chain_bright");
            end
            repeat (int'($urandom_range(0, 5))) @(posedge clk);
        end

        repeat (20) @(posedge clk);
        checkOutput("expect_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
